pe_credit_dispatcher: RTL



---
 rtl/pe_credit_dispatcher_if.sv | 64 ++++++
 rtl/pe_credit_dispatcher.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/pe_credit_dispatcher_if.sv
// rtl/pe_credit_dispatcher_if.sv - PCI job, NoC flit and result-tap signals of pe_credit_dispatcher
//
// Bundles every non-clock signal of the dispatcher.
//   master : dispatcher side (drives o_*, samples i_*)
//   slave  : environment side (host PCI stream, NoC port, result tap)
// Signals:
//   i_valid_pci/i_data_pci/o_ready_pci : PCI job stream into the dispatcher
//   o_valid/o_data/i_ready             : flit stream towards the NoC
//   i_ret_valid/i_ret_data             : result flits observed on the NoC (no backpressure)
//   o_inflight                         : number of outstanding jobs
//   o_err                              : sticky protocol error
//   i_pe_mask                          : per-PE exclusion, only with PE_MASK_EN defined
interface pe_credit_dispatcher_if #(
  parameter int N_PE        = 4,
  parameter int data_width  = 32,
  parameter int total_width = 38,
  parameter int pck_num     = 4
);
`ifdef PE_MASK_EN
  logic [N_PE-1:0]        i_pe_mask;
`endif
  logic                   i_valid_pci;
  logic [data_width-1:0]  i_data_pci;
  logic                   o_ready_pci;
  logic                   o_valid;
  logic [total_width-1:0] o_data;
  logic                   i_ready;
  logic                   i_ret_valid;
  logic [total_width-1:0] i_ret_data;
  logic [pck_num:0]       o_inflight;
  logic                   o_err;

  modport master (
`ifdef PE_MASK_EN
    input  i_pe_mask,
`endif
    input  i_valid_pci,
    input  i_data_pci,
    output o_ready_pci,
    output o_valid,
    output o_data,
    input  i_ready,
    input  i_ret_valid,
    input  i_ret_data,
    output o_inflight,
    output o_err
  );

  modport slave (
`ifdef PE_MASK_EN
    output i_pe_mask,
`endif
    output i_valid_pci,
    output i_data_pci,
    input  o_ready_pci,
    input  o_valid,
    input  o_data,
    output i_ready,
    output i_ret_valid,
    output i_ret_data,
    input  o_inflight,
    input  o_err
  );
endinterface

// File: rtl/pe_credit_dispatcher.sv
// rtl/pe_credit_dispatcher.sv - credit-limited round-robin job dispatcher from PCI to NoC
//
// Assigns each PCI job to a compute PE in round-robin order (host node skipped),
// limits every PE to CREDITS outstanding jobs and refunds credits from result
// flits seen on the NoC. Outgoing flit layout is {payload, pck_no, y, x}.
// PE index = x*Y + y.
// Ports:
//   clk : clock
//   rst : asynchronous active-high reset
//   bus : pe_credit_dispatcher_if.master (PCI stream, NoC flit stream, result tap,
//         in-flight count, sticky error)
// Optional feature macro PE_MASK_EN: adds bus.i_pe_mask; a set bit removes that
// PE from selection while its credits still refund normally.
module pe_credit_dispatcher #(
  parameter int X           = 2,
  parameter int Y           = 2,
  parameter int x_size      = 1,
  parameter int y_size      = 1,
  parameter int pck_num     = 4,
  parameter int data_width  = 32,
  parameter int total_width = 38,
  parameter int CREDITS     = 2,
  parameter int HOST_X      = 0,
  parameter int HOST_Y      = 0
) (
  input logic                    clk,
  input logic                    rst,
  pe_credit_dispatcher_if.master bus
);

  localparam int N        = X * Y;
  localparam int IW       = (N > 1) ? $clog2(N) : 1;
  localparam int CW       = $clog2(CREDITS + 1);
  localparam int HOST_IDX = HOST_X * Y + HOST_Y;
  localparam int FIRST_PE = (HOST_IDX == 0) ? 1 : 0;

  localparam logic [CW-1:0]      CRED_MAX     = CW'(CREDITS);
  localparam logic [CW-1:0]      CRED_ONE     = CW'(1);
  localparam logic [IW-1:0]      IDX_ONE      = IW'(1);
  localparam logic [IW-1:0]      IDX_LAST     = IW'(N - 1);
  localparam logic [pck_num-1:0] PCK_ONE      = pck_num'(1);
  localparam logic [pck_num:0]   INF_ONE      = (pck_num + 1)'(1);
  // Capping outstanding jobs at 2**pck_num keeps packet numbers unique in flight.
  localparam logic [pck_num:0]   INFLIGHT_CAP = {1'b1, {pck_num{1'b0}}};

  // Registered state
  logic                   valid_q;
  logic [total_width-1:0] data_q;
  logic [pck_num-1:0]     pck_no;
  logic [IW-1:0]          rr;
  logic [pck_num:0]       inflight_q;
  logic                   err_q;
  logic [N-1:0][CW-1:0]   credit;

  // Selection
  logic [N-1:0]           elig;
  logic                   any_elig;
  logic [IW-1:0]          cand;
  logic [IW-1:0]          sel;
  logic [x_size-1:0]      sel_x;
  logic [y_size-1:0]      sel_y;
  logic                   ready;
  logic                   accept;

  // Return decode
  logic [x_size-1:0]      ret_x;
  logic [y_size-1:0]      ret_y;
  logic                   ret_in_range;
  logic [IW-1:0]          ret_idx;
  logic                   ret_legal;
  logic                   ret_ok;
  logic                   ret_bad;
  logic                   unused_ret;

  // Per-PE credit counters. A same-cycle take and give cancel out; a take
  // can only happen with credit > 0 and a give only below CREDITS, so the
  // counter never leaves [0, CREDITS].
  for (genvar k = 0; k < N; k++) begin : g_pe
    logic [CW-1:0] cr;
    logic          take;
    logic          give;

    assign take = accept && (sel == IW'(k));
    assign give = ret_ok && (ret_idx == IW'(k));

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cr <= CRED_MAX;
      end else if (take && !give) begin
        cr <= cr - CRED_ONE;
      end else if (give && !take) begin
        cr <= cr + CRED_ONE;
      end
    end

    assign credit[k] = cr;

    if (k == HOST_IDX) begin : g_host
      assign elig[k] = 1'b0;
    end else begin : g_node
`ifdef PE_MASK_EN
      assign elig[k] = (cr != '0) && !bus.i_pe_mask[k];
`else
      assign elig[k] = (cr != '0);
`endif
    end
  end

  // First eligible PE at or after the round-robin pointer, wrapping.
  always_comb begin
    any_elig = 1'b0;
    sel      = '0;
    cand     = '0;
    for (int k = 0; k < N; k++) begin
      cand = IW'((int'(rr) + k) % N);
      if (!any_elig && elig[cand]) begin
        any_elig = 1'b1;
        sel      = cand;
      end
    end
  end

  assign sel_x = x_size'(int'(sel) / Y);
  assign sel_y = y_size'(int'(sel) % Y);

  // A new job may enter only when the output register is free or draining.
  assign ready  = (!valid_q || bus.i_ready) && any_elig && (inflight_q < INFLIGHT_CAP);
  assign accept = bus.i_valid_pci && ready;

  // Result flits carry their source PE in the low coordinate bits.
  assign ret_x      = bus.i_ret_data[x_size-1:0];
  assign ret_y      = bus.i_ret_data[x_size+y_size-1:x_size];
  assign unused_ret = ^bus.i_ret_data[total_width-1:x_size+y_size];

  always_comb begin
    ret_in_range = (int'(ret_x) < X) && (int'(ret_y) < Y);
    ret_idx      = ret_in_range ? IW'(int'(ret_x) * Y + int'(ret_y)) : '0;
    ret_legal    = ret_in_range && (int'(ret_idx) != HOST_IDX) && (credit[ret_idx] < CRED_MAX);
    ret_ok       = bus.i_ret_valid && ret_legal;
    ret_bad      = bus.i_ret_valid && !ret_legal;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q    <= 1'b0;
      data_q     <= '0;
      pck_no     <= '0;
      rr         <= IW'(FIRST_PE);
      inflight_q <= '0;
      err_q      <= 1'b0;
    end else begin
      if (accept) begin
        valid_q <= 1'b1;
        data_q  <= {bus.i_data_pci, pck_no, sel_y, sel_x};
        pck_no  <= pck_no + PCK_ONE;
        rr      <= (sel == IDX_LAST) ? '0 : sel + IDX_ONE;
      end else if (bus.i_ready) begin
        valid_q <= 1'b0;
      end

      if (accept && !ret_ok) begin
        inflight_q <= inflight_q + INF_ONE;
      end else if (ret_ok && !accept) begin
        inflight_q <= inflight_q - INF_ONE;
      end

      if (ret_bad) begin
        err_q <= 1'b1;
      end
    end
  end

  assign bus.o_ready_pci = ready;
  assign bus.o_valid     = valid_q;
  assign bus.o_data      = data_q;
  assign bus.o_inflight  = inflight_q;
  assign bus.o_err       = err_q;

endmodule
